pc_sequencer: RTL and testbench

Program-counter sequencer for the single-issue CPU: the consumer of the redirect signals (`pc_load`, `branch`, `jr`, `r15enable`, `exe`) that the instruction decoder produces, and the producer of `exec_in` and the link value that flow back to it. It holds the fetch PC, computes branch, JAL, JR and EXEC targets, and runs the EXEC sequence as a small state machine. The sequence is: fetch one instruction at a register address, then resume at the instruction after the EXEC.

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_target.sv | 24 ++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encodings and default widths.
package pc_sequencer_pkg;

   localparam int unsigned PC_WIDTH = 16;

   typedef enum logic [1:0] {
      PcsBoot = 2'b00,
      PcsRun  = 2'b01,
      PcsExec = 2'b10
   } pcs_state_e;

endpackage

// File: rtl/pc_target.sv
// Combinational target generation: pc+1 plus branch and JAL targets relative to pc+1.
module pc_target #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] pc_i,
   input  logic [8:0]       imm9_i,
   input  logic [11:0]      imm12_i,
   output logic [WIDTH-1:0] pc_inc_o,
   output logic [WIDTH-1:0] br_target_o,
   output logic [WIDTH-1:0] jal_target_o
);

   logic [WIDTH-1:0] imm9_sext;
   logic [WIDTH-1:0] imm12_sext;

   assign imm9_sext  = {{(WIDTH-9){imm9_i[8]}}, imm9_i};
   assign imm12_sext = {{(WIDTH-12){imm12_i[11]}}, imm12_i};

   // All sums wrap modulo 2^WIDTH.
   assign pc_inc_o     = pc_i + WIDTH'(1);
   assign br_target_o  = pc_inc_o + imm9_sext;
   assign jal_target_o = pc_inc_o + imm12_sext;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: redirects from the decoder and the two-cycle EXEC detour.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned     WIDTH     = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             pc_load,
   input  logic             branch,
   input  logic             jr,
   input  logic             r15enable,
   input  logic             exe,
   input  logic [8:0]       imm9,
   input  logic [11:0]      imm12,
   input  logic [WIDTH-1:0] reg_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] link,
   output logic             exec_in,
   output logic             fetch_valid
);

   pcs_state_e       state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] saved_pc_q;
   logic             exec_in_q;
   logic             fetch_valid_q;

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] jal_target;

   pc_target #(
      .WIDTH (WIDTH)
   ) u_pc_target (
      .pc_i         (pc_q),
      .imm9_i       (imm9),
      .imm12_i      (imm12),
      .pc_inc_o     (pc_inc),
      .br_target_o  (br_target),
      .jal_target_o (jal_target)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= PcsBoot;
         pc_q          <= RESET_VEC;
         saved_pc_q    <= '0;
         exec_in_q     <= 1'b0;
         fetch_valid_q <= 1'b0;
      end else if (!stall) begin
         case (state_q)
            PcsBoot: begin
               state_q       <= PcsRun;
               fetch_valid_q <= 1'b1;
            end
            PcsRun: begin
               if (exe) begin
                  saved_pc_q <= pc_inc;
                  pc_q       <= reg_target;
                  state_q    <= PcsExec;
                  exec_in_q  <= 1'b1;
               end else if (pc_load && jr) begin
                  pc_q <= reg_target;
               end else if (pc_load && branch) begin
                  pc_q <= br_target;
               end else if (pc_load && r15enable) begin
                  pc_q <= jal_target;
               end else begin
                  pc_q <= pc_inc;
               end
            end
            // Redirect and nested EXEC inputs are ignored; only the return is taken.
            PcsExec: begin
               pc_q      <= saved_pc_q;
               state_q   <= PcsRun;
               exec_in_q <= 1'b0;
            end
            default: begin
               state_q       <= PcsBoot;
               pc_q          <= RESET_VEC;
               exec_in_q     <= 1'b0;
               fetch_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = pc_q;
   assign link        = pc_inc;
   assign exec_in     = exec_in_q;
   assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, redirects, wrap, EXEC and its stall/nest/reset cases.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        pc_load;
   logic        branch;
   logic        jr;
   logic        r15enable;
   logic        exe;
   logic [8:0]  imm9;
   logic [11:0] imm12;
   logic [15:0] reg_target;
   logic [15:0] pc;
   logic [15:0] link;
   logic        exec_in;
   logic        fetch_valid;

   int n_pass  = 0;
   int n_total = 0;

   pc_sequencer #(
      .WIDTH     (16),
      .RESET_VEC (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .pc_load     (pc_load),
      .branch      (branch),
      .jr          (jr),
      .r15enable   (r15enable),
      .exe         (exe),
      .imm9        (imm9),
      .imm12       (imm12),
      .reg_target  (reg_target),
      .pc          (pc),
      .link        (link),
      .exec_in     (exec_in),
      .fetch_valid (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; pc_load = 0; branch = 0; jr = 0; r15enable = 0; exe = 0;
   endtask

   task automatic jump_to(input logic [15:0] tgt);
      idle();
      pc_load = 1; jr = 1; reg_target = tgt;
      step();
      idle();
   endtask

   initial begin
      rst = 0; imm9 = '0; imm12 = '0; reg_target = '0;
      idle();
      #3;
      check("rst_pc", pc, 16'h0000);
      check("rst_link", link, 16'h0001);
      check("rst_exec_in", {15'd0, exec_in}, 16'h0);
      check("rst_fv", {15'd0, fetch_valid}, 16'h0);

      step();
      rst = 1;
      check("boot_pc", pc, 16'h0000);
      check("boot_fv", {15'd0, fetch_valid}, 16'h0);
      step();
      check("run0_pc", pc, 16'h0000);
      check("run0_fv", {15'd0, fetch_valid}, 16'h1);
      step();
      check("seq1_pc", pc, 16'h0001);
      step();
      check("seq2_pc", pc, 16'h0002);

      // Branch backward and forward from 0010.
      jump_to(16'h0010);
      check("jr_0010", pc, 16'h0010);
      pc_load = 1; branch = 1; imm9 = 9'h1FE;
      step(); idle();
      check("br_neg", pc, 16'h000F);
      jump_to(16'h0010);
      pc_load = 1; branch = 1; imm9 = 9'h005;
      step(); idle();
      check("br_pos", pc, 16'h0016);

      // JAL with wrap and most-negative offset.
      jump_to(16'hFFFE);
      pc_load = 1; r15enable = 1; imm12 = 12'h003;
      #1;
      check("jal_link", link, 16'hFFFF);
      step(); idle();
      check("jal_wrap", pc, 16'h0002);
      jump_to(16'h0000);
      pc_load = 1; r15enable = 1; imm12 = 12'h800;
      step(); idle();
      check("jal_minneg", pc, 16'hF801);

      // JR qualified and unqualified; bare pc_load is sequential.
      jump_to(16'h1234);
      check("jr_1234", pc, 16'h1234);
      jr = 1; reg_target = 16'h1234;
      step(); idle();
      check("jr_noload", pc, 16'h1235);
      pc_load = 1;
      step(); idle();
      check("load_none", pc, 16'h1236);

      // Stall in RUN holds despite a redirect.
      stall = 1; pc_load = 1; jr = 1; reg_target = 16'h4444;
      step(); step();
      check("stall_run", pc, 16'h1236);
      idle();

      // Basic EXEC.
      jump_to(16'h0040);
      exe = 1; reg_target = 16'h0300;
      step(); idle();
      check("exec_tgt", pc, 16'h0300);
      check("exec_in_hi", {15'd0, exec_in}, 16'h1);
      step();
      check("exec_ret", pc, 16'h0041);
      check("exec_in_lo", {15'd0, exec_in}, 16'h0);
      step();
      check("exec_after", pc, 16'h0042);

      // EXEC stalled three cycles.
      jump_to(16'h0040);
      exe = 1; reg_target = 16'h0300;
      step(); idle();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("exec_stall_pc", pc, 16'h0300);
         check("exec_stall_ei", {15'd0, exec_in}, 16'h1);
      end
      stall = 0;
      step();
      check("exec_stall_ret", pc, 16'h0041);
      check("exec_stall_ei0", {15'd0, exec_in}, 16'h0);

      // Nested EXEC and redirects ignored in EXEC.
      jump_to(16'h0040);
      exe = 1; reg_target = 16'h0300;
      step();
      exe = 1; pc_load = 1; jr = 1; reg_target = 16'h0500;
      step(); idle();
      check("nest_ret", pc, 16'h0041);
      check("nest_ei", {15'd0, exec_in}, 16'h0);

      // Reset mid-EXEC restarts from BOOT.
      jump_to(16'h0040);
      exe = 1; reg_target = 16'h0300;
      step(); idle();
      check("pre_rst_ei", {15'd0, exec_in}, 16'h1);
      rst = 0;
      #1;
      check("mid_rst_pc", pc, 16'h0000);
      check("mid_rst_ei", {15'd0, exec_in}, 16'h0);
      check("mid_rst_fv", {15'd0, fetch_valid}, 16'h0);
      #1;
      rst = 1;
      step();
      check("reboot_pc", pc, 16'h0000);
      check("reboot_fv", {15'd0, fetch_valid}, 16'h1);
      step();
      check("reboot_seq", pc, 16'h0001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
